// File: rtl/dram_cache_pkg.sv
// Shared types and constants for the DRAM cache controller read path.
// Supplies the reorder-buffer depth helper, the stored entry type and the
// {tid, data} completion type used by the tag comparator and refill path.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 2
`endif

package dram_cache_pkg;

    localparam int ROB_ID_WIDTH   = `AXI_ID_WIDTH;
    localparam int ROB_DATA_WIDTH = `AXI_DATA_WIDTH;
    localparam int ROB_TID_WIDTH  = `TID_WIDTH;
    localparam int ROB_DEPTH      = 1 << ROB_TID_WIDTH;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0]   id;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_entry_t;

    typedef struct packed {
        logic [ROB_TID_WIDTH-1:0]  tid;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_cpl_t;

    // Number of reorder-buffer slots addressed by a tid of the given width.
    function automatic int robDepth(input int tidWidth);
        return 1 << tidWidth;
    endfunction

endpackage

// File: rtl/read_reorder_buffer_storage.sv
// rob_storage: flop array behind the read reorder buffer.
// One id write port (allocation), two data write ports (hit and miss
// completions, miss applied last so it wins on a shared tid), one
// combinational read port at the drain pointer, and the per-entry done bits.
module rob_storage #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TID_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_we_i,
    input  logic [TID_WIDTH-1:0]  id_waddr_i,
    input  logic [ID_WIDTH-1:0]   id_wdata_i,
    input  logic                  hit_we_i,
    input  logic [TID_WIDTH-1:0]  hit_waddr_i,
    input  logic [DATA_WIDTH-1:0] hit_wdata_i,
    input  logic                  miss_we_i,
    input  logic [TID_WIDTH-1:0]  miss_waddr_i,
    input  logic [DATA_WIDTH-1:0] miss_wdata_i,
    input  logic                  drain_clr_i,
    input  logic [TID_WIDTH-1:0]  raddr_i,
    output logic [ID_WIDTH-1:0]   rd_id_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [(1<<TID_WIDTH)-1:0] done_o
);

    localparam int DEPTH = 1 << TID_WIDTH;

    logic [ID_WIDTH-1:0]   idMem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] dataMem_q [DEPTH];
    logic [DEPTH-1:0]      done_q;
    logic [DEPTH-1:0]      done_d;

    // Record the host ARID for a newly allocated slot.
    always_ff @(posedge clk) begin
        if (id_we_i) begin
            idMem_q[id_waddr_i] <= id_wdata_i;
        end
    end

    // Completion data; the miss write is issued last so it overrides a hit on the same tid.
    always_ff @(posedge clk) begin
        if (hit_we_i) begin
            dataMem_q[hit_waddr_i] <= hit_wdata_i;
        end
        if (miss_we_i) begin
            dataMem_q[miss_waddr_i] <= miss_wdata_i;
        end
    end

    // Done bits: cleared on allocation and drain, set by either completion port.
    always_comb begin
        done_d = done_q;
        if (id_we_i) begin
            done_d[id_waddr_i] = 1'b0;
        end
        if (drain_clr_i) begin
            done_d[raddr_i] = 1'b0;
        end
        if (hit_we_i) begin
            done_d[hit_waddr_i] = 1'b1;
        end
        if (miss_we_i) begin
            done_d[miss_waddr_i] = 1'b1;
        end
    end

    // Done-bit register, wiped by reset so no stale entry can drain afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    assign rd_id_o   = idMem_q[raddr_i];
    assign rd_data_o = dataMem_q[raddr_i];
    assign done_o    = done_q;

endmodule

// File: rtl/read_reorder_buffer.sv
// read_reorder_buffer: hands out tids in host arrival order, accepts hit and
// miss completions in any order and returns them on the host R channel in tid
// order. Optional build macro ROB_ERR_CHECK_EN drops illegal completions and
// raises a sticky err_o.
module read_reorder_buffer
    import dram_cache_pkg::*;
#(
    parameter int ID_WIDTH     = ROB_ID_WIDTH,
    parameter int DATA_WIDTH   = ROB_DATA_WIDTH,
    parameter int TID_WIDTH    = ROB_TID_WIDTH,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [ID_WIDTH-1:0]           alloc_id_i,
    output logic [TID_WIDTH-1:0]          alloc_tid_o,
    input  logic                          hit_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] hit_data_i,
    input  logic                          miss_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] miss_data_i,
    output logic                          rob_afull_o,
`ifdef ROB_ERR_CHECK_EN
    output logic                          err_o,
`endif
    output logic [ID_WIDTH-1:0]           rid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rlast_o,
    output logic                          rvalid_o,
    input  logic                          rready_i
);

    localparam int DEPTH = robDepth(TID_WIDTH);
    localparam logic [TID_WIDTH:0] FULL_COUNT  = (TID_WIDTH+1)'(DEPTH);
    localparam logic [TID_WIDTH:0] AFULL_COUNT = (TID_WIDTH+1)'(DEPTH - AFULL_MARGIN);

    logic [TID_WIDTH-1:0]  head_q, tail_q;
    logic [TID_WIDTH:0]    count_q, count_d;
    logic                  afull_q;
    logic                  rvalid_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [TID_WIDTH-1:0]  hitTid, missTid;
    logic [DATA_WIDTH-1:0] hitData, missData;
    logic                  hitWe, missWe;
    logic                  allocFire, drainFire;
    logic [ID_WIDTH-1:0]   headId;
    logic [DATA_WIDTH-1:0] headData;
    logic [DEPTH-1:0]      doneVec;

    assign hitTid   = hit_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign hitData  = hit_data_i[DATA_WIDTH-1:0];
    assign missTid  = miss_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign missData = miss_data_i[DATA_WIDTH-1:0];

    assign alloc_ready_o = (count_q != FULL_COUNT);
    assign allocFire     = alloc_valid_i & alloc_ready_o;
    assign drainFire     = doneVec[head_q] & (~rvalid_q | rready_i);

`ifdef ROB_ERR_CHECK_EN
    logic [TID_WIDTH-1:0] hitOfs, missOfs;
    logic                 hitLive, missLive, sameTid, errSet;
    logic                 err_q;

    // A completion is legal only for an allocated, not-yet-done tid; flag everything else.
    always_comb begin
        hitOfs   = hitTid - head_q;
        missOfs  = missTid - head_q;
        hitLive  = ({1'b0, hitOfs} < count_q) & ~doneVec[hitTid];
        missLive = ({1'b0, missOfs} < count_q) & ~doneVec[missTid];
        sameTid  = hit_wren_i & miss_wren_i & (hitTid == missTid);
        hitWe    = hit_wren_i & hitLive & ~sameTid;
        missWe   = miss_wren_i & missLive;
        errSet   = (hit_wren_i & ~hitLive) | (miss_wren_i & ~missLive) | sameTid;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (errSet) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign hitWe  = hit_wren_i;
    assign missWe = miss_wren_i;
`endif

    rob_storage #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TID_WIDTH  (TID_WIDTH)
    ) u_storage (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_we_i      (allocFire),
        .id_waddr_i   (tail_q),
        .id_wdata_i   (alloc_id_i),
        .hit_we_i     (hitWe),
        .hit_waddr_i  (hitTid),
        .hit_wdata_i  (hitData),
        .miss_we_i    (missWe),
        .miss_waddr_i (missTid),
        .miss_wdata_i (missData),
        .drain_clr_i  (drainFire),
        .raddr_i      (head_q),
        .rd_id_o      (headId),
        .rd_data_o    (headData),
        .done_o       (doneVec)
    );

    // Occupancy: alloc and drain in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({allocFire, drainFire})
            2'b10:   count_d = count_q + (TID_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (TID_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the registered almost-full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            if (allocFire) begin
                tail_q <= tail_q + TID_WIDTH'(1);
            end
            if (drainFire) begin
                head_q <= head_q + TID_WIDTH'(1);
            end
            count_q <= count_d;
            afull_q <= (count_d >= AFULL_COUNT);
        end
    end

    // Host R output register: load the head entry when free, hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else if (drainFire) begin
            rvalid_q <= 1'b1;
            rid_q    <= headId;
            rdata_q  <= headData;
        end else if (rready_i) begin
            rvalid_q <= 1'b0;
        end
    end

    assign alloc_tid_o = tail_q;
    assign rob_afull_o = afull_q;
    assign rvalid_o    = rvalid_q;
    assign rlast_o     = rvalid_q;
    assign rid_o       = rid_q;
    assign rdata_o     = rdata_q;
    assign rresp_o     = 2'b00;

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Testbench for read_reorder_buffer (DEPTH=4, AFULL_MARGIN=2).
// A queue-of-transactions model predicts occupancy flags and the ordered
// beat stream; a separate monitor checks every presented beat.
module tb_read_reorder_buffer;

    localparam int IDW    = 4;
    localparam int DW     = 16;
    localparam int TW     = 2;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alloc_valid_i = 1'b0;
    logic            alloc_ready_o;
    logic [IDW-1:0]  alloc_id_i = '0;
    logic [TW-1:0]   alloc_tid_o;
    logic            hit_wren_i = 1'b0;
    logic [TW+DW-1:0] hit_data_i = '0;
    logic            miss_wren_i = 1'b0;
    logic [TW+DW-1:0] miss_data_i = '0;
    logic            rob_afull_o;
    logic [IDW-1:0]  rid_o;
    logic [DW-1:0]   rdata_o;
    logic [1:0]      rresp_o;
    logic            rlast_o;
    logic            rvalid_o;
    logic            rready_i = 1'b0;
`ifdef ROB_ERR_CHECK_EN
    logic            err_o;
`endif

    always #5 clk = ~clk;

    read_reorder_buffer #(
        .ID_WIDTH     (IDW),
        .DATA_WIDTH   (DW),
        .TID_WIDTH    (TW),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_id_i    (alloc_id_i),
        .alloc_tid_o   (alloc_tid_o),
        .hit_wren_i    (hit_wren_i),
        .hit_data_i    (hit_data_i),
        .miss_wren_i   (miss_wren_i),
        .miss_data_i   (miss_data_i),
        .rob_afull_o   (rob_afull_o),
`ifdef ROB_ERR_CHECK_EN
        .err_o         (err_o),
`endif
        .rid_o         (rid_o),
        .rdata_o       (rdata_o),
        .rresp_o       (rresp_o),
        .rlast_o       (rlast_o),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        bit             done;
    } pend_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } beat_t;

    pend_t pendQ[$];
    beat_t expQ[$];
    int    mHead = 0;
    int    mTail = 0;
    bit    mOutValid = 1'b0;
    int    total = 0;
    int    bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags the model predicts for the state after the most recent clock edge.
    task automatic checkState();
        checkOutput("alloc_ready", 32'(alloc_ready_o), 32'(pendQ.size() != DEPTH));
        checkOutput("alloc_tid", 32'(alloc_tid_o), 32'(mTail));
        checkOutput("rob_afull", 32'(rob_afull_o), 32'(pendQ.size() >= DEPTH - MARGIN));
        checkOutput("rvalid", 32'(rvalid_o), 32'(mOutValid));
        checkOutput("rlast", 32'(rlast_o), 32'(mOutValid));
        checkOutput("rresp", 32'(rresp_o), 32'd0);
`ifdef ROB_ERR_CHECK_EN
        checkOutput("err_clean", 32'(err_o), 32'd0);
`endif
    endtask

    // Transaction-level model: entries in arrival order, oldest done entry leaves when the output is free.
    task automatic modelStep(input bit av, input logic [IDW-1:0] aid,
                             input bit hv, input int ht, input logic [DW-1:0] hd,
                             input bit mv, input int mt, input logic [DW-1:0] md,
                             input bit rr);
        bit drain;
        bit afire;
        int k;
        drain = (pendQ.size() > 0) && pendQ[0].done && (!mOutValid || rr);
        afire = av && (pendQ.size() < DEPTH);
        if (hv) begin
            k = (ht - mHead + DEPTH) % DEPTH;
            if (k < pendQ.size()) begin
                pendQ[k].data = hd;
                pendQ[k].done = 1'b1;
            end
        end
        if (mv) begin
            k = (mt - mHead + DEPTH) % DEPTH;
            if (k < pendQ.size()) begin
                pendQ[k].data = md;
                pendQ[k].done = 1'b1;
            end
        end
        if (drain) begin
            expQ.push_back('{id: pendQ[0].id, data: pendQ[0].data});
            void'(pendQ.pop_front());
            mHead = (mHead + 1) % DEPTH;
            mOutValid = 1'b1;
        end else if (rr) begin
            mOutValid = 1'b0;
        end
        if (afire) begin
            pendQ.push_back('{id: aid, data: '0, done: 1'b0});
            mTail = (mTail + 1) % DEPTH;
        end
    endtask

    // One clock of stimulus: check the settled state, drive the next inputs, advance the model.
    task automatic applyStimulus(input bit av, input logic [IDW-1:0] aid,
                                 input bit hv, input int ht, input logic [DW-1:0] hd,
                                 input bit mv, input int mt, input logic [DW-1:0] md,
                                 input bit rr);
        @(posedge clk);
        #1;
        checkState();
        alloc_valid_i = av;
        alloc_id_i    = aid;
        hit_wren_i    = hv;
        hit_data_i    = {TW'(ht), hd};
        miss_wren_i   = mv;
        miss_data_i   = {TW'(mt), md};
        rready_i      = rr;
        modelStep(av, aid, hv, ht, hd, mv, mt, md, rr);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 0, '0, 1'b0, 0, '0, rr);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        alloc_valid_i = 1'b0;
        hit_wren_i    = 1'b0;
        miss_wren_i   = 1'b0;
        rready_i      = 1'b0;
        @(posedge clk);
        #1;
        pendQ.delete();
        expQ.delete();
        mHead     = 0;
        mTail     = 0;
        mOutValid = 1'b0;
        checkOutput("rst_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("rst_rid", 32'(rid_o), 32'd0);
        checkOutput("rst_rdata", 32'(rdata_o), 32'd0);
        checkOutput("rst_rlast", 32'(rlast_o), 32'd0);
        checkOutput("rst_ready", 32'(alloc_ready_o), 32'd1);
        checkOutput("rst_tid", 32'(alloc_tid_o), 32'd0);
        checkOutput("rst_afull", 32'(rob_afull_o), 32'd0);
        rst_n = 1'b1;
    endtask

    // Monitor: every presented beat must match the oldest expected beat; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rvalid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(rvalid_o), 32'd0);
                end else begin
                    checkOutput("rid", 32'(rid_o), 32'(expQ[0].id));
                    checkOutput("rdata", 32'(rdata_o), 32'(expQ[0].data));
                    if (rready_i) begin
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int cand[$];
        bit av, hv, mv, rr;
        int ht, mt, idx;
        logic [IDW-1:0] aid;
        logic [DW-1:0]  hd, md;

        doReset();

        // single read: id 3, hit with 0xA5
        applyStimulus(1'b1, 4'd3, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 0, 16'h00A5, 1'b0, 0, '0, 1'b1);
        idle(3, 1'b1);

        // reorder: ids 1,2,3 completed third/first/second
        base = mTail;
        applyStimulus(1'b1, 4'd1, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
        applyStimulus(1'b1, 4'd2, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 0, '0, 1'b1, (base + 2) % DEPTH, 16'h3333, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, base, 16'h1111, 1'b0, 0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, (base + 1) % DEPTH, 16'h2222, 1'b0, 0, '0, 1'b1);
        idle(5, 1'b1);

        // back-pressure: two done entries held for five cycles
        base = mTail;
        applyStimulus(1'b1, 4'd7, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, base, 16'hBEEF, 1'b1, (base + 1) % DEPTH, 16'hCAFE, 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cand.delete();
            foreach (pendQ[i]) begin
                if (!pendQ[i].done) cand.push_back(i);
            end
            av  = ($urandom_range(0, 1) == 1);
            aid = IDW'($urandom);
            hd  = DW'($urandom);
            md  = DW'($urandom);
            rr  = ($urandom_range(0, 9) < 7);
            hv  = 1'b0;
            mv  = 1'b0;
            ht  = 0;
            mt  = 0;
            if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                idx = $urandom_range(0, cand.size() - 1);
                hv  = 1'b1;
                ht  = (mHead + cand[idx]) % DEPTH;
                cand.delete(idx);
            end
            if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                idx = $urandom_range(0, cand.size() - 1);
                mv  = 1'b1;
                mt  = (mHead + cand[idx]) % DEPTH;
            end
`ifndef ROB_ERR_CHECK_EN
            else if (hv && $urandom_range(0, 9) == 0) begin
                mv = 1'b1;
                mt = ht;
            end
`endif
            applyStimulus(av, aid, hv, ht, hd, mv, mt, md, rr);
        end
        idle(6, 1'b1);
        checkOutput("beats_drained", 32'(expQ.size()), 32'd0);

        // reset with three pending entries, then a fresh allocation restarts at tid 0
        applyStimulus(1'b1, 4'd4, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
        doReset();
        applyStimulus(1'b1, 4'd9, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
        idle(2, 1'b1);

`ifdef ROB_ERR_CHECK_EN
        // completion to an unallocated tid is dropped and latches err_o
        applyStimulus(1'b0, '0, 1'b1, 3, 16'hDEAD, 1'b0, 0, '0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("err_set", 32'(err_o), 32'd1);
        checkOutput("err_no_beat", 32'(rvalid_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_reorder_buffer.md
# read_reorder_buffer

Restores AXI read-response order for the DRAM cache controller. Each host read is given a transaction ID (tid) in arrival order. Each tid is later completed, in any order, by one of two sources: the tag comparator on a read hit, or the refill path on a read miss. The block returns completions to the host AXI R channel strictly in tid order, and sits between those two producers and the host R port.

## Interface
- ID_WIDTH, `AXI_ID_WIDTH, host AXI ID width
- DATA_WIDTH, `AXI_DATA_WIDTH, beat width
- TID_WIDTH, `TID_WIDTH, tid width; DEPTH = 2**TID_WIDTH entries
- AFULL_MARGIN, 2, free-slot threshold for rob_afull_o
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- alloc_valid_i  in  1  new host read accepted upstream
- alloc_ready_o  out  1  slot free
- alloc_id_i  in  ID_WIDTH  host ARID to return
- alloc_tid_o  out  TID_WIDTH  tid assigned (= tail pointer)
- hit_wren_i  in  1  read-hit completion from tag comparator
- hit_data_i  in  TID_WIDTH+DATA_WIDTH  {tid, data}
- miss_wren_i  in  1  read-miss completion from refill path
- miss_data_i  in  TID_WIDTH+DATA_WIDTH  {tid, data}
- rob_afull_o  out  1  almost full, back-pressure to tag comparator
- rid_o  out  ID_WIDTH  host R ID
- rdata_o  out  DATA_WIDTH  host R data
- rresp_o  out  2  always 2'b00 (OKAY)
- rlast_o  out  1  equals rvalid_o (single-beat reads)
- rvalid_o / rready_i  out / in  1  host R handshake

## Operation
- Pointers: tail (alloc), head (drain), both TID_WIDTH bits, wrap modulo DEPTH. count is TID_WIDTH+1 bits.
- Each entry holds id, data, and a done bit.
- Allocation fires when alloc_valid_i & alloc_ready_o. It writes id[tail], clears done[tail], and increments tail.
- alloc_ready_o = (count != DEPTH).
- Completion: hit_wren_i writes data[tid] and sets done[tid]. miss_wren_i does the same on a second, independent write port. Both ports may write distinct tids in the same cycle.
- Drain: when done[head] & (!rvalid_o | rready_i), the output register loads {id[head], data[head]}, rvalid_o is set, done[head] is cleared, and head increments. If no entry drains and rready_i is high, rvalid_o clears.
- count: +1 on alloc, -1 on drain; unchanged when both happen in the same cycle.
- rob_afull_o is registered: 1 when the next count ≥ DEPTH − AFULL_MARGIN.
- Same-tid hit and miss in one cycle: the miss port wins.
- Out-of-order completion: tid k+1 done before tid k → nothing is issued until k is done, then k and k+1 are issued in consecutive accepted beats.

## Timing
- Reset values: rvalid_o 0, rid_o 0, rdata_o 0, rlast_o 0, rresp_o 0, alloc_ready_o 1, alloc_tid_o 0, rob_afull_o 0. All done bits 0, pointers 0, count 0.
- Reset mid-operation discards all entries, with no partial drain.
- Alloc to alloc_tid_o update: 1 cycle.
- Completion write to rvalid_o (entry at head, output free): 2 cycles. The done bit is set at edge E, and the output loads at edge E+1.
- Sustained throughput: 1 beat/cycle with rready_i held high.
- rvalid_o is held with stable rid_o/rdata_o until rready_i is high.

## Configuration
- ROB_ERR_CHECK_EN defined:
  - a completion whose tid is not allocated (outside [head, tail) with count), or whose done bit is already 1, is dropped;
  - a sticky output err_o (1 bit, reset 0) is set;
  - a same-tid dual write sets err_o, and the miss port still wins.
- ROB_ERR_CHECK_EN undefined: no checks, completions are written unconditionally, and err_o is absent.

## Structure
- dram_cache_pkg holds:
  - the DEPTH constant derived from TID_WIDTH;
  - typedef rob_entry_t {id, data};
  - the completion typedef {tid, data}, shared with the tag comparator.
- Sub-module rob_storage: DEPTH-entry flop array with two data write ports, one id write port and one combinational read port, plus the done-bit vector.
- Control and pointers stay in read_reorder_buffer.

## Test plan
- Single read: alloc id=3; hit tid=0, data=0xA5 → rvalid_o two cycles later with rid_o=3, rdata_o=0xA5, rlast_o=1, rresp_o=0.
- Reorder: alloc ids 1,2,3; complete tids 2,0,1 via miss/hit/hit → beats issued with rid 1,2,3 in order, back-to-back.
- Full and wrap: DEPTH=4, AFULL_MARGIN=2.
  - After the 2nd alloc, rob_afull_o=1; after the 4th, alloc_ready_o=0.
  - Drain one → alloc_ready_o=1. The next alloc gets tid 0 (wrap).
- Back-pressure: rready_i=0 for 5 cycles with 2 entries done → rvalid_o and rid_o/rdata_o stay stable. Release → 2 beats on consecutive cycles.
- Simultaneous: hit tid 0 and miss tid 1 in the same cycle, while alloc and drain happen together → both written, count unchanged. With ROB_ERR_CHECK_EN, a hit on an unallocated tid → dropped and err_o=1.
- Reset while 3 entries are pending → all outputs return to reset values, and a new alloc gets tid 0.
